maze_generator: RTL and testbench

MAZE_GENERATOR -- requirements
Module: maze_generator

---
 rtl/mazegen_pkg.sv | 21 ++
 rtl/mazegen_lfsr.sv | 47 ++++
 rtl/maze_generator.sv | 192 +++++++++++++++++++
 tb/tb_maze_generator.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mazegen_pkg.sv
// ---------------------------------------------------------------------------
// mazegen_pkg
// Shared definitions for the maze generator:
//   mazegen_state_e   - controller states (IDLE, FILL, CARVE, OPEN, DONE)
//   LFSR_TAPS         - feedback mask for taps 16,14,13,11 (bits 15,13,12,10)
//   LFSR_SEED_DEFAULT - value loaded on reset and in place of a zero seed
// ---------------------------------------------------------------------------
package mazegen_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        CARVE = 3'd2,
        OPEN  = 3'd3,
        DONE  = 3'd4
    } mazegen_state_e;

    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

endpackage

// File: rtl/mazegen_lfsr.sv
// ---------------------------------------------------------------------------
// mazegen_lfsr
// 16-bit Fibonacci LFSR, taps 16,14,13,11. Shifts left; the XOR of the tap
// bits enters at bit 0, which is the bit the carver consumes.
// Ports:
//   clk   in   clock
//   rst   in   asynchronous active-high reset, loads LFSR_SEED_DEFAULT
//   load  in   load seed (a zero seed is replaced by LFSR_SEED_DEFAULT,
//              because the all-zero state would lock the register)
//   seed  in   16-bit seed value
//   step  in   advance one position (ignored while load is high)
//   value out  current register contents
// ---------------------------------------------------------------------------
module mazegen_lfsr
    import mazegen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] value
);

    logic [15:0] value_q;
    logic [15:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = (seed == 16'h0000) ? LFSR_SEED_DEFAULT : seed;
        end else if (step) begin
            value_d = {value_q[14:0], ^(value_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= LFSR_SEED_DEFAULT;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/maze_generator.sv
// ---------------------------------------------------------------------------
// maze_generator
// Builds a perfect maze with the binary-tree algorithm. The grid is
// size x size; cells sit at odd (x,y), everything else starts as wall.
// Sequence: FILL rewrites every row to all-ones (one row per cycle),
// CARVE visits one cell per cycle in row-major order and knocks out either
// its north or east wall, OPEN punches the entrance (row 0, column 1) and the
// exit (last row, column ex), then DONE holds the result.
//
// Handshake: start is a single-cycle request with no ready signal. It is
// accepted only when the controller is in IDLE or DONE (busy=0); a start seen
// while busy is dropped. seed is sampled in the same cycle as an accepted
// start. done stays high, and maze stays frozen, until the next accepted
// start or reset.
//
// Build option: MAZEGEN_RANDOM_EXIT_EN - when defined, the exit column is
// drawn from the LFSR in OPEN; otherwise it is fixed at size-2.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   start    in   one-cycle generate request
//   seed     in   16-bit LFSR seed (0 selects 16'hACE1)
//   maze     out  size rows of size bits, maze[y][x], 1 = wall
//   busy     out  high in FILL, CARVE, OPEN
//   done     out  high in DONE
//   state_o  out  current controller state (debug)
//   lfsr_o   out  current LFSR contents (debug)
// ---------------------------------------------------------------------------
module maze_generator
    import mazegen_pkg::*;
#(
    parameter int size = 9,
    parameter int N    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [15:0]     seed,
    output logic [size-1:0] maze [size],
    output logic            busy,
    output logic            done,
    output logic [2:0]      state_o,
    output logic [15:0]     lfsr_o
);

    localparam logic [N-1:0] ONE        = N'(1);
    localparam logic [N-1:0] TWO        = N'(2);
    localparam logic [N-1:0] CELL_FIRST = N'(1);
    localparam logic [N-1:0] CELL_LAST  = N'(size - 2);
    localparam logic [N-1:0] ROW_LAST   = N'(size - 1);

    mazegen_state_e  state_q, state_d;
    logic [N-1:0]    cx_q, cx_d;
    logic [N-1:0]    cy_q, cy_d;
    logic [size-1:0] maze_q [size];
    logic [size-1:0] maze_d [size];

    logic            lfsr_load;
    logic            lfsr_step;
    logic [15:0]     lfsr_value;

    logic [N-1:0]    east_x;
    logic [N-1:0]    north_y;
    logic [N-1:0]    exit_x;

    mazegen_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .seed  (seed),
        .step  (lfsr_step),
        .value (lfsr_value)
    );

    assign east_x  = cx_q + ONE;
    assign north_y = cy_q - ONE;

`ifdef MAZEGEN_RANDOM_EXIT_EN
    // Mask covers enough LFSR bits to index every cell column; the result is
    // always odd, and anything past the last cell column is pulled back to it.
    localparam int HALF_CELLS = (size - 1) / 2;
    localparam int EXIT_MASK  = (1 << $clog2(HALF_CELLS)) - 1;

    logic [15:0] exit_wide;

    always_comb begin
        exit_wide = ((lfsr_value & 16'(EXIT_MASK)) << 1) | 16'd1;
        if (exit_wide > 16'(size - 2)) begin
            exit_wide = 16'(size - 2);
        end
    end

    assign exit_x = exit_wide[N-1:0];
`else
    assign exit_x = CELL_LAST;
`endif

    always_comb begin
        state_d   = state_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        maze_d    = maze_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    lfsr_load = 1'b1;
                    cy_d      = '0;
                    cx_d      = CELL_FIRST;
                    state_d   = FILL;
                end
            end

            FILL: begin
                // cy doubles as the row pointer while filling
                maze_d[cy_q] = '1;
                if (cy_q == ROW_LAST) begin
                    cy_d    = CELL_FIRST;
                    cx_d    = CELL_FIRST;
                    state_d = CARVE;
                end else begin
                    cy_d = cy_q + ONE;
                end
            end

            CARVE: begin
                lfsr_step            = 1'b1;
                maze_d[cy_q][cx_q]   = 1'b0;
                // Top row can only go east; right column can only go north;
                // the top-right cell is the root of the tree and keeps both.
                if (cy_q == CELL_FIRST) begin
                    if (cx_q != CELL_LAST) begin
                        maze_d[cy_q][east_x] = 1'b0;
                    end
                end else if (cx_q == CELL_LAST) begin
                    maze_d[north_y][cx_q] = 1'b0;
                end else if (lfsr_value[0]) begin
                    maze_d[north_y][cx_q] = 1'b0;
                end else begin
                    maze_d[cy_q][east_x] = 1'b0;
                end

                if (cx_q == CELL_LAST) begin
                    cx_d = CELL_FIRST;
                    if (cy_q == CELL_LAST) begin
                        state_d = OPEN;
                    end else begin
                        cy_d = cy_q + TWO;
                    end
                end else begin
                    cx_d = cx_q + TWO;
                end
            end

            OPEN: begin
                maze_d[0][1]             = 1'b0;
                maze_d[ROW_LAST][exit_x] = 1'b0;
                state_d                  = DONE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cx_q    <= CELL_FIRST;
            cy_q    <= CELL_FIRST;
            for (int r = 0; r < size; r++) begin
                maze_q[r] <= '1;
            end
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            maze_q  <= maze_d;
        end
    end

    assign maze    = maze_q;
    assign busy    = (state_q == FILL) || (state_q == CARVE) || (state_q == OPEN);
    assign done    = (state_q == DONE);
    assign state_o = state_q;
    assign lfsr_o  = lfsr_value;

endmodule

// File: tb/tb_maze_generator.sv
// ---------------------------------------------------------------------------
// tb_maze_generator
// Directed bench for maze_generator at size=9. The seed=1 maze and its final
// LFSR value were worked out by hand; other seeds are checked for the
// perfect-maze properties (border, openings, cell count, flood-fill reach,
// open-square count of a spanning tree) and for run-to-run equality.
// ---------------------------------------------------------------------------
module tb_maze_generator;

    localparam int SIZE = 9;
    localparam int LAT  = 27;

    typedef logic [SIZE*SIZE-1:0] flat_t;

    logic            clk   = 1'b0;
    logic            rst   = 1'b1;
    logic            start = 1'b0;
    logic [15:0]     seed  = 16'h0000;
    logic [SIZE-1:0] maze [SIZE];
    logic            busy;
    logic            done;
    logic [2:0]      state_o;
    logic [15:0]     lfsr_o;

    int    pass_cnt  = 0;
    int    check_cnt = 0;
    int    first_done;
    flat_t golden_s1;
    flat_t all_walls;
    flat_t snap_a;
    flat_t snap_b;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    maze_generator #(.size(SIZE), .N(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .seed    (seed),
        .maze    (maze),
        .busy    (busy),
        .done    (done),
        .state_o (state_o),
        .lfsr_o  (lfsr_o)
    );

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic flat_t flat_maze();
        flat_t f;
        for (int y = 0; y < SIZE; y++) begin
            f[y*SIZE +: SIZE] = maze[y];
        end
        return f;
    endfunction

    task automatic check_rows(input string tag, input flat_t exp);
        for (int y = 0; y < SIZE; y++) begin
            check($sformatf("%s row%0d", tag, y), 32'(maze[y]), 32'(exp[y*SIZE +: SIZE]));
        end
    endtask

    task automatic check_structure(input string tag);
        int z0;
        int z8;
        int sides;
        int cells;
        int opens;
        int reached;
        int exit_reached;
        logic [SIZE-1:0] rch [SIZE];
        z0 = 0; z8 = 0; sides = 0; cells = 0; opens = 0; reached = 0; exit_reached = 0;
        for (int x = 0; x < SIZE; x++) begin
            if (!maze[0][x]) z0++;
            if (!maze[SIZE-1][x]) z8++;
        end
        for (int y = 0; y < SIZE; y++) begin
            if (!maze[y][0] || !maze[y][SIZE-1]) sides++;
            for (int x = 0; x < SIZE; x++) begin
                if (!maze[y][x]) opens++;
                if ((y % 2 == 1) && (x % 2 == 1) && !maze[y][x]) cells++;
            end
        end
        check({tag, " entrance"}, 32'(maze[0][1]), 32'd0);
        check({tag, " row0 openings"}, 32'(z0), 32'd1);
        check({tag, " row8 openings"}, 32'(z8), 32'd1);
        check({tag, " side walls"}, 32'(sides), 32'd0);
        check({tag, " cell count"}, 32'(cells), 32'd16);
        // spanning tree: 16 cells + 15 passages + entrance + exit
        check({tag, " open squares"}, 32'(opens), 32'd33);
        for (int y = 0; y < SIZE; y++) rch[y] = '0;
        rch[0][1] = !maze[0][1];
        repeat (SIZE * SIZE) begin
            for (int y = 0; y < SIZE; y++) begin
                for (int x = 0; x < SIZE; x++) begin
                    if (!maze[y][x] && !rch[y][x]) begin
                        if ((y > 0 && rch[y-1][x]) || (y < SIZE-1 && rch[y+1][x]) ||
                            (x > 0 && rch[y][x-1]) || (x < SIZE-1 && rch[y][x+1])) begin
                            rch[y][x] = 1'b1;
                        end
                    end
                end
            end
        end
        for (int y = 1; y < SIZE; y += 2) begin
            for (int x = 1; x < SIZE; x += 2) begin
                if (rch[y][x]) reached++;
            end
        end
        for (int x = 0; x < SIZE; x++) begin
            if (rch[SIZE-1][x]) exit_reached++;
        end
        check({tag, " cells reached"}, 32'(reached), 32'd16);
        check({tag, " exit reached"}, 32'(exit_reached), 32'd1);
    endtask

    // ---------------- driver ----------------
    // Pulses start with seed s before edge 1, then watches 32 edges. busy must
    // be high through edge 26 and done must rise exactly at edge 27. With
    // extra set, start is pulsed again before edges 3 and 10 (with a different
    // seed) and must be ignored.
    task automatic run_gen(input logic [15:0] s, input bit extra, input string tag);
        int bad_flags;
        bad_flags  = 0;
        first_done = 0;
        @(negedge clk);
        start = 1'b1;
        seed  = s;
        for (int e = 1; e <= 32; e++) begin
            @(posedge clk);
            #1;
            if (done && first_done == 0) first_done = e;
            if (busy !== (e < LAT) || done !== (e >= LAT)) bad_flags++;
            @(negedge clk);
            start = extra && ((e + 1 == 3) || (e + 1 == 10));
            seed  = 16'h5A5A;
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(first_done), 32'(LAT));
        check({tag, " busy/done profile"}, 32'(bad_flags), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // hand-derived maze for seed 16'h0001 (bit x of row y = maze[y][x])
        golden_s1[0*SIZE +: SIZE] = 9'h1FD;
        golden_s1[1*SIZE +: SIZE] = 9'h101;
        golden_s1[2*SIZE +: SIZE] = 9'h17F;
        golden_s1[3*SIZE +: SIZE] = 9'h101;
        golden_s1[4*SIZE +: SIZE] = 9'h17F;
        golden_s1[5*SIZE +: SIZE] = 9'h101;
        golden_s1[6*SIZE +: SIZE] = 9'h157;
        golden_s1[7*SIZE +: SIZE] = 9'h151;
        golden_s1[8*SIZE +: SIZE] = 9'h17F;
        all_walls = '1;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // idle after reset, no start
        repeat (20) @(negedge clk);
        check("idle busy", 32'(busy), 32'd0);
        check("idle done", 32'(done), 32'd0);
        check("idle state", 32'(state_o), 32'd0);
        check("idle lfsr", 32'(lfsr_o), 32'hACE1);
        check_rows("idle", all_walls);

        // seed 1 against the hand-derived maze
        run_gen(16'h0001, 1'b0, "s1");
        check_rows("s1", golden_s1);
        check("s1 lfsr", 32'(lfsr_o), 32'h002D);
        check_structure("s1");
        snap_a = flat_maze();

        // DONE holds everything still
        repeat (10) @(negedge clk);
        check_rows("s1 frozen", golden_s1);
        check("s1 frozen lfsr", 32'(lfsr_o), 32'h002D);
        check("s1 frozen state", 32'(state_o), 32'd4);
        check("s1 frozen done", 32'(done), 32'd1);

        // repeat run from DONE with the same seed
        run_gen(16'h0001, 1'b0, "s1 again");
        check_rows("s1 again", snap_a);

        // zero seed behaves as 16'hACE1
        run_gen(16'h0000, 1'b0, "s0");
        check_structure("s0");
        snap_b = flat_maze();
        run_gen(16'hACE1, 1'b0, "sACE1");
        check_rows("sACE1 vs s0", snap_b);

        // starts during generation are ignored
        run_gen(16'h0001, 1'b1, "s1 extra starts");
        check_rows("s1 extra starts", golden_s1);

        // reset in the middle of CARVE
        @(negedge clk);
        start = 1'b1;
        seed  = 16'h1234;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        check("abort pre-reset state", 32'(state_o), 32'd2);
        #2 rst = 1'b1;
        #1;
        check_rows("abort", all_walls);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort state", 32'(state_o), 32'd0);
        check("abort lfsr", 32'(lfsr_o), 32'hACE1);
        @(negedge clk);
        rst = 1'b0;
        run_gen(16'h0001, 1'b0, "after reset");
        check_rows("after reset", golden_s1);

        // one more arbitrary seed for structure
        run_gen(16'hBEEF, 1'b0, "sBEEF");
        check_structure("sBEEF");

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
